icache_refill_ctrl: RTL

- Sequences I-cache line refills on the AHB master side.
- On a cache miss it issues one read-only WRAP4 word burst, critical word first, for the missing 16-byte line.
- Each returned beat is written into the line data array, and completion or error is reported to the cache FSM.
- Sits between the cache lookup/miss logic and the downstream AHB memory slave.

---
 rtl/icache_refill_ctrl_if.sv | 40 ++++
 rtl/icache_refill_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl_if.sv
// Bundle between the I-cache refill controller, the cache miss FSM, the AHB
// master port and the line data array.
interface icache_refill_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              miss_req;
    logic [ADDR_W-1:0] miss_addr;
    logic              miss_ack;
    logic              busy;

    logic [ADDR_W-1:0] m_haddr;
    logic [1:0]        m_htrans;
    logic [2:0]        m_hburst;
    logic [2:0]        m_hsize;
    logic              m_hwrite;
    logic              m_hready;
    logic              m_hresp;
    logic [DATA_W-1:0] m_hrdata;

    logic              fill_we;
    logic [1:0]        fill_idx;
    logic [DATA_W-1:0] fill_data;
    logic [ADDR_W-1:0] fill_line;
    logic              crit_valid;
    logic              fill_done;
    logic              fill_err;

    modport master (
        input  miss_req, miss_addr, m_hready, m_hresp, m_hrdata,
        output miss_ack, busy, m_haddr, m_htrans, m_hburst, m_hsize, m_hwrite,
               fill_we, fill_idx, fill_data, fill_line, crit_valid, fill_done, fill_err
    );

    modport slave (
        output miss_req, miss_addr, m_hready, m_hresp, m_hrdata,
        input  miss_ack, busy, m_haddr, m_htrans, m_hburst, m_hsize, m_hwrite,
               fill_we, fill_idx, fill_data, fill_line, crit_valid, fill_done, fill_err
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill sequencer: one critical-word-first WRAP4 AHB read burst
// per miss, each returned word written into the line array one cycle later.
//
// state | meaning
// IDLE  | waiting for miss_req
// ADDR  | issuing the 4 address beats (data phases overlap)
// DRAIN | last address accepted, collecting remaining data
// ERR   | ERROR response seen, waiting for its second cycle
module icache_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rstn,
    icache_refill_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, ADDR, DRAIN, ERR} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        acnt_q, acnt_d;
    logic [1:0]        dcnt_q, dcnt_d;
    logic              dpend_q, dpend_d;
    logic              fill_we_q, fill_we_d;
    logic [1:0]        fill_idx_q, fill_idx_d;
    logic [DATA_W-1:0] fill_data_q, fill_data_d;
    logic              crit_q, crit_d;
    logic              done_q, done_d;

    logic              miss_ack;
    logic              fill_err;
    logic [1:0]        htrans;
    logic [2:0]        hburst;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        aidx;
    logic              capture;
    logic              err_first;
    logic              unused_addr_lsbs;

    assign aidx      = off_q + acnt_q;
    assign capture   = dpend_q && bus.m_hready && !bus.m_hresp
                       && (state_q == ADDR || state_q == DRAIN);
    // First cycle of the two-cycle AHB ERROR response.
    assign err_first = dpend_q && !bus.m_hready && bus.m_hresp;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        off_d       = off_q;
        acnt_d      = acnt_q;
        dcnt_d      = dcnt_q;
        dpend_d     = dpend_q;
        fill_we_d   = 1'b0;
        fill_idx_d  = fill_idx_q;
        fill_data_d = fill_data_q;
        crit_d      = 1'b0;
        done_d      = 1'b0;
        miss_ack    = 1'b0;
        fill_err    = 1'b0;
        htrans      = HTRANS_IDLE;
        hburst      = 3'b000;
        haddr       = '0;

        if (capture) begin
            fill_we_d   = 1'b1;
            fill_data_d = bus.m_hrdata;
            fill_idx_d  = off_q + dcnt_q;
            crit_d      = (dcnt_q == 2'd0);
            done_d      = (dcnt_q == 2'd3);
            dcnt_d      = dcnt_q + 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.miss_req) begin
                    miss_ack = 1'b1;
                    base_d   = {bus.miss_addr[ADDR_W-1:4], 4'b0000};
                    off_d    = bus.miss_addr[3:2];
                    acnt_d   = 2'd0;
                    dcnt_d   = 2'd0;
                    dpend_d  = 1'b0;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                htrans = (acnt_q == 2'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
                hburst = HBURST_WRAP4;
                haddr  = {base_q[ADDR_W-1:4], aidx, 2'b00};
                if (err_first) begin
                    dpend_d = 1'b0;
                    state_d = ERR;
                end else if (bus.m_hready) begin
                    dpend_d = 1'b1;
                    if (acnt_q == 2'd3) begin
                        state_d = DRAIN;
                    end else begin
                        acnt_d = acnt_q + 2'd1;
                    end
                end
            end
            DRAIN: begin
                if (err_first) begin
                    dpend_d = 1'b0;
                    state_d = ERR;
                end else if (bus.m_hready) begin
                    dpend_d = 1'b0;
                end
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (bus.m_hready) begin
                    fill_err = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            base_q      <= '0;
            off_q       <= '0;
            acnt_q      <= '0;
            dcnt_q      <= '0;
            dpend_q     <= 1'b0;
            fill_we_q   <= 1'b0;
            fill_idx_q  <= '0;
            fill_data_q <= '0;
            crit_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            off_q       <= off_d;
            acnt_q      <= acnt_d;
            dcnt_q      <= dcnt_d;
            dpend_q     <= dpend_d;
            fill_we_q   <= fill_we_d;
            fill_idx_q  <= fill_idx_d;
            fill_data_q <= fill_data_d;
            crit_q      <= crit_d;
            done_q      <= done_d;
        end
    end

    // Byte offset within the word is irrelevant for a line fill.
    assign unused_addr_lsbs = ^bus.miss_addr[1:0];

    assign bus.miss_ack   = miss_ack;
    assign bus.busy       = (state_q != IDLE);
    assign bus.m_haddr    = haddr;
    assign bus.m_htrans   = htrans;
    assign bus.m_hburst   = hburst;
    assign bus.m_hsize    = 3'b010;
    assign bus.m_hwrite   = 1'b0;
    assign bus.fill_we    = fill_we_q;
    assign bus.fill_idx   = fill_idx_q;
    assign bus.fill_data  = fill_data_q;
    assign bus.fill_line  = base_q;
    assign bus.crit_valid = crit_q;
    assign bus.fill_done  = done_q;
    assign bus.fill_err   = fill_err;

endmodule
